// File: rtl/burst_rr_arbiter_if.sv
// Requester/downstream handshake bundle for burst_rr_arbiter.
// slave = arbiter side, master = requesters plus downstream environment.
interface burst_rr_arbiter_if #(
  parameter int NumReq = 2,
  parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
);
  logic [NumReq-1:0] req_i;
  logic [NumReq-1:0] last_i;
  logic [NumReq-1:0] gnt_o;
  logic              valid_o;
  logic              last_o;
  logic [IdxW-1:0]   idx_o;
  logic              ready_i;
  logic              busy_o;

  modport slave (
    input  req_i, last_i, ready_i,
    output gnt_o, valid_o, last_o, idx_o, busy_o
  );

  modport master (
    output req_i, last_i, ready_i,
    input  gnt_o, valid_o, last_o, idx_o, busy_o
  );
endinterface

// File: rtl/burst_rr_arbiter.sv
// Burst-granular round-robin arbiter: zero-cycle grant, winner locked until last beat or beat cap.
// Backpressure: nothing advances unless valid_o & ready_i; flush_i clears state and blocks transfer.
module burst_rr_arbiter #(
  parameter int NumReq   = 2,
  parameter int MaxBeats = 16,
  parameter int IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  burst_rr_arbiter_if.slave bus
);
  localparam int              CntW   = $clog2(MaxBeats + 1);
  localparam logic [CntW-1:0] CapCnt = CntW'(MaxBeats - 1);
  localparam logic            Single = (MaxBeats == 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e            st_q, st_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [IdxW-1:0]   lock_q, lock_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   sel;
  logic [NumReq-1:0] gnt;
  logic              valid, last, busy;
  logic [IdxW-1:0]   idx;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] i);
    if (int'(i) == NumReq - 1) return '0;
    return i + 1'b1;
  endfunction

  // Scan downward so the candidate closest to rr_q is written last and wins.
  always_comb begin
    int              j;
    logic [IdxW-1:0] cand;
    j    = 0;
    cand = '0;
    sel  = rr_q;
    for (int k = NumReq - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NumReq) j = j - NumReq;
      cand = IdxW'(j);
      if (bus.req_i[cand]) sel = cand;
    end
  end

  always_comb begin
    st_d   = st_q;
    rr_d   = rr_q;
    lock_d = lock_q;
    cnt_d  = cnt_q;
    gnt    = '0;
    valid  = 1'b0;
    last   = 1'b0;
    idx    = rr_q;
    busy   = 1'b0;
    if (flush_i) begin
      st_d   = IDLE;
      rr_d   = '0;
      lock_d = '0;
      cnt_d  = '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          valid = |bus.req_i;
          idx   = sel;
          last  = bus.last_i[sel] | Single;
          if (valid && bus.ready_i) begin
            gnt[sel] = 1'b1;
            if (last) begin
              rr_d = wrap_inc(sel);
            end else begin
              st_d   = BURST;
              lock_d = sel;
              cnt_d  = CntW'(1);
            end
          end
        end
        BURST: begin
          idx   = lock_q;
          valid = bus.req_i[lock_q];
          last  = bus.last_i[lock_q] | (cnt_q == CapCnt);
          busy  = 1'b1;
          if (valid && bus.ready_i) begin
            gnt[lock_q] = 1'b1;
            cnt_d       = cnt_q + 1'b1;
            if (last) begin
              st_d  = IDLE;
              rr_d  = wrap_inc(lock_q);
              cnt_d = '0;
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q   <= IDLE;
      rr_q   <= '0;
      lock_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      rr_q   <= rr_d;
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.gnt_o   = gnt;
  assign bus.valid_o = valid;
  assign bus.last_o  = last;
  assign bus.idx_o   = idx;
  assign bus.busy_o  = busy;
endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Bench for burst_rr_arbiter (4 requesters, 4-beat cap): directed scenarios plus
// randomized traffic against a queue-free owner/priority model of the arbitration rules.
module tb_burst_rr_arbiter;
  localparam int N = 4;
  localparam int M = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad   = 0;

  burst_rr_arbiter_if #(.NumReq(N)) bus ();

  burst_rr_arbiter #(.NumReq(N), .MaxBeats(M)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
    bus.req_i   = r;
    bus.last_i  = l;
    bus.ready_i = rdy;
    #2;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    drive('0, '0, 1'b1);
    tick();
    flush = 1'b0;
  endtask

  // Observed outputs packed as {gnt, valid, last, idx, busy}.
  function automatic logic [9:0] obs();
    return {bus.gnt_o, bus.valid_o, bus.last_o, bus.idx_o, bus.busy_o};
  endfunction

  function automatic logic [9:0] mk(input logic [3:0] g, input logic v, input logic l,
                                    input int i, input logic b);
    logic [1:0] i2;
    i2 = 2'(i);
    return {g, v, l, i2, b};
  endfunction

  task automatic test_reset();
    logic [9:0] e;
    rst_n = 1'b0;
    drive('0, '0, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    drive('0, '0, 1'b1);
    e = mk(4'b0000, 0, 0, 0, 0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset_outputs got %b want %b", obs(), e);
    end
  endtask

  task automatic test_rr_rotate();
    logic [9:0] e;
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      e = mk(4'(1 << (k % N)), 1, 1, k % N, 0);
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL rr_rotate k=%0d got %b want %b", k, obs(), e);
      end
      tick();
    end
  endtask

  task automatic test_burst_lock();
    logic [9:0] e;
    do_flush();
    for (int b = 1; b <= 3; b++) begin
      drive(4'b0011, {2'b00, 1'b1, (b == 3)}, 1'b1);
      e = mk(4'b0001, 1, (b == 3), 0, (b > 1));
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL burst_lock beat=%0d got %b want %b", b, obs(), e);
      end
      tick();
    end
    drive(4'b0011, 4'b0010, 1'b1);
    e = mk(4'b0010, 1, 1, 1, 0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL burst_handover got %b want %b", obs(), e);
    end
    tick();
  endtask

  task automatic test_cap_release();
    logic [9:0] e;
    do_flush();
    for (int b = 1; b <= 4; b++) begin
      drive(4'b0011, 4'b0010, 1'b1);
      e = mk(4'b0001, 1, (b == 4), 0, (b > 1));
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL cap_beat beat=%0d got %b want %b", b, obs(), e);
      end
      tick();
    end
    drive(4'b0011, 4'b0010, 1'b1);
    e = mk(4'b0010, 1, 1, 1, 0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL cap_next_req1 got %b want %b", obs(), e);
    end
    tick();
    e = mk(4'b0001, 1, 0, 0, 0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL cap_req0_again got %b want %b", obs(), e);
    end
    tick();
    drive('0, '0, 1'b1);
    e = mk(4'b0000, 0, 0, 0, 1);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL cap_new_burst_locked got %b want %b", obs(), e);
    end
  endtask

  task automatic test_req_drop();
    logic [9:0] e;
    do_flush();
    drive(4'b0001, 4'b0000, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0100, 4'b0000, 1'b1);
      e = mk(4'b0000, 0, 0, 0, 1);
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL drop_hold c=%0d got %b want %b", c, obs(), e);
      end
      tick();
    end
    for (int b = 2; b <= 4; b++) begin
      drive(4'b0101, 4'b0000, 1'b1);
      e = mk(4'b0001, 1, (b == 4), 0, 1);
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL drop_resume beat=%0d got %b want %b", b, obs(), e);
      end
      tick();
    end
    drive(4'b0100, 4'b0100, 1'b1);
    e = mk(4'b0100, 1, 1, 2, 0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL drop_then_req2 got %b want %b", obs(), e);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [9:0] e;
    logic [6:0] o7;
    do_flush();
    drive(4'b0001, 4'b0001, 1'b1);
    tick();
    drive(4'b1000, 4'b0000, 1'b1);
    tick();
    tick();
    flush = 1'b1;
    drive(4'b1001, 4'b0000, 1'b1);
    o7 = {bus.gnt_o, bus.valid_o, bus.last_o, bus.busy_o};
    total++;
    if (o7 !== 7'b0) begin
      bad++;
      $display("FAIL flush_same_cycle got %b want %b", o7, 7'b0);
    end
    tick();
    flush = 1'b0;
    drive(4'b1001, 4'b0000, 1'b1);
    e = mk(4'b0001, 1, 0, 0, 0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL flush_rr_zero got %b want %b", obs(), e);
    end
    tick();
  endtask

  task automatic test_stall_reset();
    logic [9:0] e;
    do_flush();
    drive(4'b0010, 4'b0000, 1'b1);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(4'b0010, 4'b0000, 1'b0);
      e = mk(4'b0000, 1, 0, 1, 1);
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL stall c=%0d got %b want %b", c, obs(), e);
      end
      tick();
    end
    for (int b = 2; b <= 3; b++) begin
      drive(4'b0010, 4'b0000, 1'b1);
      e = mk(4'b0010, 1, 0, 1, 1);
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL stall_resume beat=%0d got %b want %b", b, obs(), e);
      end
      tick();
    end
    drive(4'b0010, 4'b0000, 1'b0);
    e = mk(4'b0000, 1, 1, 1, 1);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL stall_cap_pending got %b want %b", obs(), e);
    end
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    rst_n = 1'b1;
    flush = 1'b0;
    drive('0, '0, 1'b1);
    e = mk(4'b0000, 0, 0, 0, 0);
    total++;
    if (obs() !== e) begin
      bad++;
      $display("FAIL reset_mid_burst got %b want %b", obs(), e);
    end
  endtask

  task automatic test_random();
    int         owner, beats, prio, w, ei;
    logic [N-1:0] r, l, eg;
    logic       rdy, fl, ev, el, eb, xfer;
    logic [1:0] ei2;
    rst_n = 1'b0;
    drive('0, '0, 1'b1);
    tick();
    rst_n = 1'b1;
    owner = -1;
    beats = 0;
    prio  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r   = N'($urandom);
      l   = N'($urandom);
      rdy = ($urandom_range(3) != 0);
      fl  = ($urandom_range(31) == 0);
      flush = fl;
      drive(r, l, rdy);
      eg = '0; ev = 0; el = 0; eb = 0; ei = 0; w = -1; xfer = 0;
      if (!fl) begin
        if (owner < 0) begin
          for (int k = 0; k < N; k++)
            if (w < 0 && r[(prio + k) % N]) w = (prio + k) % N;
          ev = (w >= 0);
          ei = ev ? w : prio;
          el = l[ei] || (M == 1);
        end else begin
          ei = owner;
          eb = 1;
          ev = r[owner];
          el = l[owner] || (beats == M - 1);
        end
        xfer = ev && rdy;
        if (xfer) eg[ei] = 1'b1;
      end
      ei2 = 2'(ei);
      total++;
      if ({bus.gnt_o, bus.valid_o, bus.last_o, bus.busy_o} !== {eg, ev, el, eb}) begin
        bad++;
        $display("FAIL random cyc=%0d gnt/valid/last/busy got %b want %b", cyc,
                 {bus.gnt_o, bus.valid_o, bus.last_o, bus.busy_o}, {eg, ev, el, eb});
      end
      if (!fl) begin
        total++;
        if (bus.idx_o !== ei2) begin
          bad++;
          $display("FAIL random_idx cyc=%0d got %0d want %0d", cyc, bus.idx_o, ei2);
        end
      end
      total++;
      if (!$onehot0(bus.gnt_o) || (bus.gnt_o != 0 && !(bus.valid_o && bus.ready_i))) begin
        bad++;
        $display("FAIL random_invariant cyc=%0d gnt %b valid %b ready %b", cyc,
                 bus.gnt_o, bus.valid_o, bus.ready_i);
      end
      tick();
      if (fl) begin
        owner = -1; beats = 0; prio = 0;
      end else if (xfer) begin
        if (owner < 0) begin
          if (el) prio = (ei + 1) % N;
          else begin
            owner = ei;
            beats = 1;
          end
        end else if (el) begin
          prio  = (owner + 1) % N;
          owner = -1;
          beats = 0;
        end else begin
          beats++;
        end
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    bus.req_i   = '0;
    bus.last_i  = '0;
    bus.ready_i = 1'b1;
    #1;
    test_reset();
    test_rr_rotate();
    test_burst_lock();
    test_cap_release();
    test_req_drop();
    test_flush();
    test_stall_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
